// File: rtl/seq_divider_16by8_if.sv
// Operand/result handshake bundle for the sequential 16/8 divider.
// The master drives operands and result-accept; the slave returns results.
interface seq_divider_16by8_if #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16by8.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Single operation in flight; valid/ready on both operand and result sides.
module seq_divider_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input logic                clk,
  input logic                rst,
  seq_divider_16by8_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int unsigned R_W   = DIVISOR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [R_W-1:0]        r_q,         r_d;
  logic [DIVIDEND_W-1:0] q_q,         q_d;
  logic [DIVISOR_W-1:0]  dvsr_q,      dvsr_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  dbz_q,       dbz_d;
  logic [DIVIDEND_W-1:0] quot_q,      quot_d;
  logic [DIVISOR_W-1:0]  rem_q,       rem_d;

  logic [R_W-1:0]        r_shift;
  logic [R_W-1:0]        r_diff;
  logic [R_W-1:0]        r_step;
  logic [DIVIDEND_W-1:0] q_step;
  logic                  q_bit;

  // One restoring step on the {R,Q} pair
  always_comb begin
    r_shift = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    r_diff  = r_shift - {1'b0, dvsr_q};
    q_bit   = (r_shift >= {1'b0, dvsr_q});
    r_step  = q_bit ? r_diff : r_shift;
    q_step  = {q_q[DIVIDEND_W-2:0], q_bit};
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    quot_d      = quot_q;
    rem_d       = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          dvsr_d     = bus.divisor;
          in_ready_d = 1'b0;
          if (bus.divisor != '0) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = bus.dividend;
          end else begin
            // Zero divisor short-circuits: saturated quotient, low dividend bits as remainder
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            quot_d      = '1;
            rem_d       = bus.dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end
        end
      end

      ST_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          quot_d      = q_step;
          rem_d       = r_step[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: vector table, directed corners,
// and a randomised handshake run checked through a result scoreboard.
module tb_seq_divider_16by8;
  localparam int unsigned DDW   = 16;
  localparam int unsigned DSW   = 8;
  localparam int unsigned N_RND = 1500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_16by8_if #(.DIVIDEND_W(DDW), .DIVISOR_W(DSW)) bus ();

  seq_divider_16by8 #(.DIVIDEND_W(DDW), .DIVISOR_W(DSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  res_t sb[$];
  vec_t tbl[12];
  int   checks   = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   accepted = 1'b0;

  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t e;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {8'd0, b};
      e.r   = 8'(a % {8'd0, b});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge
  task automatic tick();
    res_t e;
    accepted = 1'b0;
    @(negedge clk);
    if (!rst && bus.in_valid && bus.in_ready) begin
      sb.push_back(model(bus.dividend, bus.divisor));
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_empty: result q=0x%0h r=0x%0h with nothing pending", bus.quotient, bus.remainder);
      end else begin
        e = sb.pop_front();
        check("sb_result", 32'({bus.div_by_zero, bus.remainder, bus.quotient}), 32'({e.dbz, e.r, e.q}));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Issue one operation, then wait for out_valid; lat counts edges after the accepting edge
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    int n;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 100) begin
      tick();
      n++;
    end
    if (!accepted) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready never accepted %0d/%0d", a, b);
    end
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, "_quotient"},  32'(bus.quotient),    32'd0);
    check({tag, "_remainder"}, 32'(bus.remainder),   32'd0);
    check({tag, "_dbz"},       32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    int lat;
    int c0;
    int n;
    int issued;
    int saw_valid;

    tbl[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[1]  = '{16'd65535, 8'd255, 16'h0101,  8'd0,   1'b0};
    tbl[2]  = '{16'd65535, 8'd1,   16'hFFFF,  8'd0,   1'b0};
    tbl[3]  = '{16'd5,     8'd0,   16'hFFFF,  8'd5,   1'b1};
    tbl[4]  = '{16'd100,   8'd200, 16'd0,     8'd100, 1'b0};
    tbl[5]  = '{16'd12,    8'd4,   16'd3,     8'd0,   1'b0};
    tbl[6]  = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0};
    tbl[7]  = '{16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0};
    tbl[8]  = '{16'h1234,  8'h10,  16'h0123,  8'h04,  1'b0};
    tbl[9]  = '{16'hABCD,  8'd0,   16'hFFFF,  8'hCD,  1'b1};
    tbl[10] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0};
    tbl[11] = '{16'd65535, 8'd254, 16'd258,   8'd3,   1'b0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Vector table with result accepted immediately
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat);
      check("tbl_latency",   32'(lat), (tbl[i].b == 8'd0) ? 32'd0 : 32'd16);
      check("tbl_quotient",  32'(bus.quotient),    32'(tbl[i].q));
      check("tbl_remainder", 32'(bus.remainder),   32'(tbl[i].r));
      check("tbl_dbz",       32'(bus.div_by_zero), 32'(tbl[i].dbz));
      tick();
      check("tbl_idle_ready", 32'(bus.in_ready), 32'd1);
    end

    // Back-to-back issue with out_ready held high
    bus.dividend = 16'd65535;
    bus.divisor  = 8'd255;
    bus.in_valid = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 100) begin tick(); n++; end
    c0 = acc_cyc;
    bus.divisor = 8'd1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b0;
    check("b2b_spacing", 32'(acc_cyc - c0), 32'd18);
    n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Zero divisor: result right after the accepting edge
    bus.out_ready = 1'b0;
    run_op(16'd5, 8'd0, lat);
    check("dbz_latency", 32'(lat), 32'd0);
    check("dbz_quotient", 32'(bus.quotient), 32'hFFFF);
    check("dbz_remainder", 32'(bus.remainder), 32'h05);
    check("dbz_flag", 32'(bus.div_by_zero), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Result held stable under back-pressure
    run_op(16'd100, 8'd200, lat);
    check("hold_latency", 32'(lat), 32'd16);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_quotient",  32'(bus.quotient),  32'h0000);
      check("hold_remainder", 32'(bus.remainder), 32'h64);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("hold_release_ready", 32'(bus.in_ready),  32'd1);
    check("hold_release_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset in the middle of a calculation abandons it
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.in_valid = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    sb.delete();
    rst = 1'b0;
    saw_valid = 0;
    repeat (20) begin
      tick();
      if (bus.out_valid) saw_valid++;
    end
    check("midreset_no_result", 32'(saw_valid), 32'd0);
    bus.out_ready = 1'b1;
    run_op(16'd12, 8'd4, lat);
    check("post_reset_latency",   32'(lat), 32'd16);
    check("post_reset_quotient",  32'(bus.quotient),  32'd3);
    check("post_reset_remainder", 32'(bus.remainder), 32'd0);
    tick();

    // Random operands with random in_valid/out_ready, checked via scoreboard
    issued = 0;
    n = 0;
    while ((issued < int'(N_RND) || sb.size() != 0 || bus.in_valid) && n < 80000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && issued < int'(N_RND) && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.dividend = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       bus.divisor = 8'd0;
          1:       bus.divisor = 8'($urandom_range(1, 3));
          2:       bus.divisor = 8'd255;
          default: bus.divisor = 8'($urandom);
        endcase
      end
      tick();
      n++;
      if (accepted) begin
        issued++;
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
      end
    end
    check("random_issued",  32'(issued),    32'(N_RND));
    check("random_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
